fib_checker: RTL
================

FIB_CHECKER -- requirements
Module: fib_checker

Interface
REQ-001: The block SHALL have parameter width, default 10, giving the sample width in bits.
REQ-002: The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003: The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004: The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-005: The block SHALL have port in_data, input, width bits: the sequence sample under check.
REQ-006: The block SHALL have port in_ready, output, 1 bit: the checker accepts a sample this cycle.
REQ-007: The block SHALL have port resync, input, 1 bit: restart learning from the IDLE state.
REQ-008: The block SHALL have port res_valid, output, 1 bit: a one-cycle pulse qualifying res_match.
REQ-009: The block SHALL have port res_match, output, 1 bit: the checked sample equals the predicted sample.
REQ-010: The block SHALL have port locked, output, 1 bit: the state is TRACK.
REQ-011: The block SHALL have port err, output, 1 bit: the state is ERR (sticky).
REQ-012: The block SHALL have port match_cnt, output, 16 bits: the saturating count of matched samples.

Function
REQ-013: A sample SHALL be accepted only when in_valid=1, in_ready=1 and resync=0 in the same cycle.
REQ-014: in_ready SHALL be 0 in the ERR state and 0 in any cycle with resync=1; otherwise in_ready SHALL be 1.
REQ-015: The state machine SHALL have the states IDLE, SEED, TRACK and ERR.
REQ-016: IDLE, on acceptance: p1<=in_data, go to SEED, no result pulse.
REQ-017: SEED, on acceptance: p0<=p1, p1<=in_data, go to TRACK, no result pulse.
REQ-018: TRACK, on acceptance: the prediction SHALL be (p0+p1) mod 2^width, with the carry discarded, so that a wrapping generator still matches.
REQ-019: TRACK, on a match: p0<=p1, p1<=in_data, stay in TRACK, match_cnt increments.
REQ-020: TRACK, on a mismatch: go to ERR, p0 and p1 hold, match_cnt holds.
REQ-021: res_valid SHALL pulse exactly one cycle after each sample accepted in TRACK, with res_match registered alongside it; both SHALL have 1-cycle latency.
REQ-022: res_match SHALL hold its last value while res_valid=0.
REQ-023: ERR SHALL persist until resync=1; a pending in_valid in ERR SHALL be back-pressured, not dropped.
REQ-024: resync=1 in any state SHALL force IDLE on the next edge and clear p0, p1 and err; resync SHALL take priority over a simultaneous in_valid.
REQ-025: match_cnt SHALL saturate at 16'hFFFF and SHALL be cleared by reset only, not by resync.
REQ-026: locked SHALL be the registered state==TRACK, and err SHALL be the registered state==ERR, with no combinational path from the inputs.

Reset
REQ-027: While rstn=0, independent of clk: state=IDLE, p0=p1=0, res_valid=0, res_match=0, match_cnt=0, locked=0, err=0.
REQ-028: While rstn=0, in_ready SHALL be 1.
REQ-029: Reset asserted mid-TRACK SHALL discard history; after release, the next two accepted samples re-seed.
REQ-030: Reset release SHALL require no dummy cycles: a sample on the first edge after release SHALL be accepted.

Configuration
REQ-031: With macro FIB_CHECKER_CNT_EN defined, the 16-bit saturating match counter SHALL be built and drive match_cnt.
REQ-032: With FIB_CHECKER_CNT_EN undefined, no counter flops SHALL exist, match_cnt SHALL be tied to 16'h0000, and all other behaviour SHALL be identical.

Structure
REQ-033: A shared package fib_pkg SHALL hold the state enum typedef (IDLE/SEED/TRACK/ERR) and the constant CNT_W=16.
REQ-034: fib_checker SHALL have no sub-modules; the predictor adder SHALL be inline.

Verification
REQ-035: The bench SHALL cover: reset, then in_valid every cycle with 1,2,3,5,8 -> three res_valid pulses all with res_match=1, locked=1 after the 2nd sample, match_cnt=3.
REQ-036: The bench SHALL cover wrap with width=10: 377,610,987,573 -> two matches, since 610+987=1597 mod 1024=573.
REQ-037: The bench SHALL cover mismatch: 1,2,4 -> res_valid with res_match=0, err=1 and in_ready=0 from the next cycle; in_valid=1 held with 7 -> no acceptance.
REQ-038: The bench SHALL cover a simultaneous event: resync=1 with in_valid=1 in ERR -> sample not accepted, IDLE next cycle, err=0, and 7 is accepted as the first seed on the following cycle.
REQ-039: The bench SHALL cover reset mid-stream: rstn low for 1 cycle after 1,2,3 -> all outputs at reset values, match_cnt=0; then 5,8,13 -> the 13 matches.
REQ-040: The bench SHALL cover saturation with FIB_CHECKER_CNT_EN defined (force near 16'hFFFE) -> the count stops at 16'hFFFF; without the macro, match_cnt=0 throughout.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence checker.
package fib_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    TRACK = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/fib_checker.sv
// Streaming Fibonacci checker: learns two seeds, then verifies each sample equals the
// wrapped sum of the previous two. Define FIB_CHECKER_CNT_EN to build the match counter.
module fib_checker
  import fib_pkg::*;
#(
  parameter int width = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  input  logic             resync,
  output logic             res_valid,
  output logic             res_match,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt
);

  state_t             state_reg, state_next;
  logic [width-1:0]   p0_reg, p0_next;
  logic [width-1:0]   p1_reg, p1_next;
  logic               res_valid_reg, res_valid_next;
  logic               res_match_reg, res_match_next;
  logic               locked_reg;
  logic               err_reg;
  logic [width-1:0]   pred;
  logic               accept;
  logic               is_match;

  // Carry is dropped on purpose so a wrapping generator keeps matching.
  assign pred     = p0_reg + p1_reg;
  assign is_match = (in_data == pred);
  assign accept   = in_valid && !resync && (state_reg != ERR);
  assign in_ready = !rstn || ((state_reg != ERR) && !resync);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      p0_reg        <= '0;
      p1_reg        <= '0;
      res_valid_reg <= 1'b0;
      res_match_reg <= 1'b0;
      locked_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      p0_reg        <= p0_next;
      p1_reg        <= p1_next;
      res_valid_reg <= res_valid_next;
      res_match_reg <= res_match_next;
      locked_reg    <= (state_next == TRACK);
      err_reg       <= (state_next == ERR);
    end
  end

  always_comb begin
    state_next     = state_reg;
    p0_next        = p0_reg;
    p1_next        = p1_reg;
    res_valid_next = 1'b0;
    res_match_next = res_match_reg;
    if (resync) begin
      state_next = IDLE;
      p0_next    = '0;
      p1_next    = '0;
    end else if (accept) begin
      case (state_reg)
        IDLE: begin
          p1_next    = in_data;
          state_next = SEED;
        end
        SEED: begin
          p0_next    = p1_reg;
          p1_next    = in_data;
          state_next = TRACK;
        end
        TRACK: begin
          res_valid_next = 1'b1;
          res_match_next = is_match;
          if (is_match) begin
            p0_next = p1_reg;
            p1_next = in_data;
          end else begin
            state_next = ERR;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

`ifdef FIB_CHECKER_CNT_EN
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_reg;

  assign cnt_inc = accept && (state_reg == TRACK) && is_match;

  // Only reset clears the count; resync leaves it alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (cnt_inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign match_cnt = cnt_reg;
`else
  assign match_cnt = '0;
`endif

  assign res_valid = res_valid_reg;
  assign res_match = res_match_reg;
  assign locked    = locked_reg;
  assign err       = err_reg;

endmodule
